// File: rtl/tick_counter_if.sv
// Control/status bundle for tick_counter: run controls and load/limit in, count and pulses out.
interface tick_counter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_enable;
  logic             i_dir;
  logic             i_load;
  logic [WIDTH-1:0] i_load_value;
  logic [WIDTH-1:0] i_limit;
  logic [WIDTH-1:0] o_counter;
  logic             o_tick;
  logic             o_led;

  modport master (
    output i_enable, i_dir, i_load, i_load_value, i_limit,
    input  o_counter, o_tick, o_led
  );

  modport slave (
    input  i_enable, i_dir, i_load, i_load_value, i_limit,
    output o_counter, o_tick, o_led
  );
endinterface

// File: rtl/tick_counter.sv
// Up/down counter with programmable terminal value, terminal tick pulse and toggling LED.
// Define TICK_COUNTER_PRESCALER_EN to build the PRESCALE step divider; otherwise step = i_enable.
module tick_counter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned SATURATE = 0
) (
  input logic           i_clk,
  input logic           i_reset,
  tick_counter_if.slave bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("tick_counter: WIDTH must be at least 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("tick_counter: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             tick_q, tick_d;
  logic             led_q, led_d;
  logic             sat_q, sat_d;
  logic             dir_q, dir_d;
  logic             step;

`ifdef TICK_COUNTER_PRESCALER_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;

  always_comb begin
    step = bus.i_enable && (ps_q == PsLast);
    ps_d = ps_q;
    if (bus.i_load) begin
      ps_d = '0;
    end else if (bus.i_enable) begin
      ps_d = step ? '0 : ps_q + PsW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step = bus.i_enable;
`endif

  logic dir_chg;
  logic sat_eff;
  logic at_term;

  always_comb begin
    // A direction change seen while running releases a saturated counter.
    dir_chg   = bus.i_enable && (bus.i_dir != dir_q);
    sat_eff   = sat_q && !dir_chg;
    at_term   = bus.i_dir ? (counter_q >= bus.i_limit) : (counter_q == '0);
    counter_d = counter_q;
    tick_d    = 1'b0;
    led_d     = led_q;
    sat_d     = sat_eff;
    dir_d     = bus.i_enable ? bus.i_dir : dir_q;
    if (bus.i_load) begin
      counter_d = bus.i_load_value;
      sat_d     = 1'b0;
    end else if (step && !sat_eff) begin
      if (at_term) begin
        tick_d = 1'b1;
        led_d  = ~led_q;
        if (SATURATE != 0) begin
          sat_d = 1'b1;
        end else begin
          counter_d = bus.i_dir ? '0 : bus.i_limit;
        end
      end else begin
        counter_d = bus.i_dir ? counter_q + WIDTH'(1) : counter_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      counter_q <= '0;
      tick_q    <= 1'b0;
      led_q     <= 1'b0;
      sat_q     <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
      sat_q     <= sat_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.o_counter = counter_q;
  assign bus.o_tick    = tick_q;
  assign bus.o_led     = led_q;

endmodule

// File: doc/tick_counter.md
# tick_counter

Parametrised up/down counter with a programmable terminal value, a prescaler, a one-cycle terminal pulse and a toggling LED output. It replaces the fixed 32-bit free-running counter as the time base for the LED-flashing subsystem. It sits between the board clock and the LED/GPIO logic, and can be chained through `o_tick` to build slower time bases.

## Interface
- `WIDTH`, 32: counter width in bits (≥2).
- `PRESCALE`, 100000: number of enabled `i_clk` cycles per count step (≥1; only used with `TICK_COUNTER_PRESCALER_EN`).
- `SATURATE`, 0: 0 = wrap at terminal; 1 = hold at terminal.

Ports:
- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_enable`, in, 1: 1 = run; 0 = freeze prescaler, counter and saturation flag.
- `i_dir`, in, 1: 1 = count up; 0 = count down.
- `i_load`, in, 1: synchronous load of `i_load_value`.
- `i_load_value`, in, WIDTH: value written by `i_load`.
- `i_limit`, in, WIDTH: terminal value; sampled on every step.
- `o_counter`, out, WIDTH: current count.
- `o_tick`, out, 1: registered one-cycle pulse on each terminal event.
- `o_led`, out, 1: toggles on each terminal event.

## Operation
- Reset values: `o_counter`=0, `o_tick`=0, `o_led`=0, prescaler=0, sat flag=0.
- Step strobe: the prescaler counts enabled cycles from 0 to PRESCALE-1. Step is asserted on the cycle it equals PRESCALE-1, and the prescaler then returns to 0.
- Up mode, on a step:
  - If counter ≥ `i_limit`, this is a terminal event. Counter goes to 0 (wrap) or holds (SATURATE=1).
  - Otherwise the counter increments by 1.
- Down mode, on a step:
  - If counter == 0, this is a terminal event. Counter goes to `i_limit` (wrap) or holds at 0 (SATURATE=1).
  - Otherwise the counter decrements by 1.
- Terminal event: `o_tick`=1 for exactly one cycle and `o_led` inverts.
- Saturation: with SATURATE=1, the first terminal event sets the sat flag.
  - While the flag is set, steps produce no tick, no LED toggle and no counter change.
  - The flag clears on `i_load` or when `i_dir` changes value.
- Priority: reset > `i_load` > step.
  - Load writes `i_load_value`, clears the prescaler and the sat flag, and suppresses the step in that cycle.
  - Load does not generate a tick, whether or not `i_enable` is set.
- `i_limit`=0: every step in up mode is terminal and the counter stays at 0.
- Limit lowered below the current count in up mode: the next step is terminal (≥ compare), so the counter never runs away.
- Arithmetic is modulo 2^WIDTH; no other overflow path exists.
- Reset mid-count clears all state immediately. Counting resumes from 0 on the first enabled edge after release.

## Timing
- `o_counter` updates on the same edge where step is asserted, i.e. the PRESCALE-th enabled edge after the previous step or load.
- `o_tick` and `o_led` change on that same edge, registered from the terminal condition. There is no combinational path from inputs to outputs.
- Tick period in wrap/up mode is (`i_limit`+1)×PRESCALE cycles.
- `i_enable` low for N cycles delays the next step by exactly N cycles.

## Configuration
- `TICK_COUNTER_PRESCALER_EN` defined: the prescaler is built and PRESCALE applies.
- Not defined: no prescaler logic; step = `i_enable` every cycle; PRESCALE is ignored.

## Test plan
All scenarios use WIDTH=8 and PRESCALE=4 with the macro defined, unless stated otherwise.
- Reset release, enable=1, dir=1, limit=3: counter sequence 0,1,2,3,0 with changes every 4 cycles. `o_tick` is high for one cycle at each 3→0 transition (every 16 cycles) and `o_led` toggles there.
- dir=0, load 2: counter sequence 2,1,0,3,2 with limit=3. Tick occurs on the 0→3 transition. The load cycle produces no tick.
- SATURATE=1, up, limit=5: counter reaches 5, one tick is produced, then the counter holds at 5 with no further ticks. Toggling `i_dir` clears the flag and counting down resumes.
- Counter=6, limit changed to 2: the next step is terminal and the counter goes to 0.
- Load asserted on the same cycle as a step: counter = `i_load_value`, no increment, prescaler restarts at 0.
- Macro undefined: counter increments every enabled cycle. Assert `i_reset` mid-count: outputs are 0 immediately, before the next edge.
